// File: rtl/pipeline_pkg.sv
// Shared definitions for the 4-stage pipeline core: opcodes, default
// parameters, stage control record and small decode helpers.
package pipeline_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int NUM_REGS_DEF   = 32;
  localparam int DMEM_DEPTH_DEF = 16;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_LDI = 6'b000010;
  localparam logic [5:0] OP_LW  = 6'b000011;
  localparam logic [5:0] OP_SW  = 6'b000100;

  // Decoded operation class carried down the pipe.
  typedef enum logic [2:0] {
    K_NOP = 3'd0,
    K_ADD = 3'd1,
    K_SUB = 3'd2,
    K_LDI = 3'd3,
    K_LW  = 3'd4,
    K_SW  = 3'd5
  } kind_e;

  // Control part of every stage register; data fields live beside it
  // because their width depends on the core's DATA_W parameter.
  typedef struct packed {
    logic       valid;
    kind_e      kind;
    logic [4:0] dst;
  } stage_ctl_t;

  function automatic kind_e decode_op(input logic [5:0] op);
    case (op)
      OP_ADD:  return K_ADD;
      OP_SUB:  return K_SUB;
      OP_LDI:  return K_LDI;
      OP_LW:   return K_LW;
      OP_SW:   return K_SW;
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic writes_reg(input kind_e k);
    return (k == K_ADD) || (k == K_SUB) || (k == K_LDI) || (k == K_LW);
  endfunction

endpackage

// File: rtl/pipeline_regfile.sv
// Register file: two combinational read ports, one write port, r0 reads as
// zero, and a write-through bypass so a same-cycle write is seen by readers.
module pipeline_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_REGS)-1:0] i_ra_idx,
  output logic [DATA_W-1:0]           o_ra_data,
  input  logic [$clog2(NUM_REGS)-1:0] i_rb_idx,
  output logic [DATA_W-1:0]           o_rb_data,
  input  logic                        i_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_wa_idx,
  input  logic [DATA_W-1:0]           i_wd
);

  localparam int RW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Storage update; index 0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[RW'(i)] <= '0;
      end
    end else if (i_we && (i_wa_idx != '0)) begin
      r_regs[i_wa_idx] <= i_wd;
    end
  end

  // Read ports with write-through bypass; r0 overrides everything.
  always_comb begin
    o_ra_data = r_regs[i_ra_idx];
    if (i_we && (i_wa_idx == i_ra_idx)) o_ra_data = i_wd;
    if (i_ra_idx == '0) o_ra_data = '0;

    o_rb_data = r_regs[i_rb_idx];
    if (i_we && (i_wa_idx == i_rb_idx)) o_rb_data = i_wd;
    if (i_rb_idx == '0) o_rb_data = '0;
  end

endmodule

// File: rtl/pipeline_core_p.sv
// Four-stage in-order core (ID, EX, MEM, WB) with EX-stage forwarding,
// a single-cycle load-use interlock and a small word-addressed data memory.
module pipeline_core_p
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 instruction,
  output logic                        result_valid,
  output logic [$clog2(NUM_REGS)-1:0] result_rd,
  output logic [DATA_W-1:0]           result,
  output logic [31:0]                 retired_count,
  output logic [31:0]                 stall_count
);

  localparam int         RW       = $clog2(NUM_REGS);
  localparam int         AW       = $clog2(DMEM_DEPTH);
  localparam logic [4:0] IDX_MASK = 5'(NUM_REGS - 1);

  // ID stage holds the raw instruction; decode happens combinationally.
  logic              r_id_vld;
  logic [31:0]       r_id_instr;

  stage_ctl_t        r_ex;
  logic [4:0]        r_ex_rs;
  logic [4:0]        r_ex_rt;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic [DATA_W-1:0] r_ex_imm;

  stage_ctl_t        r_mem;
  logic [DATA_W-1:0] r_mem_res;
  logic [DATA_W-1:0] r_mem_sd;

  stage_ctl_t        r_wb;
  logic [DATA_W-1:0] r_wb_res;

  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
  logic [31:0]       r_retired;
  logic [31:0]       r_stalls;

  kind_e             w_id_kind;
  logic [4:0]        w_id_rs;
  logic [4:0]        w_id_rt;
  logic [4:0]        w_id_rd;
  logic [4:0]        w_id_dst;
  logic              w_id_use_rs;
  logic              w_id_use_rt;
  logic [31:0]       w_imm32;
  logic [DATA_W-1:0] w_id_imm;
  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic              w_stall;

  logic              w_wb_we;
  logic              w_mem_fwd;
  logic [DATA_W-1:0] w_ex_a;
  logic [DATA_W-1:0] w_ex_b;
  logic [DATA_W-1:0] w_ex_res;

  logic [AW-1:0]     w_mem_addr;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_mem_val;

  // ID decode: operand usage, destination and sign-extended immediate.
  always_comb begin
    w_id_kind   = decode_op(r_id_instr[31:26]);
    w_id_rs     = r_id_instr[25:21] & IDX_MASK;
    w_id_rt     = r_id_instr[20:16] & IDX_MASK;
    w_id_rd     = r_id_instr[15:11] & IDX_MASK;
    w_imm32     = {{16{r_id_instr[15]}}, r_id_instr[15:0]};
    w_id_imm    = w_imm32[DATA_W-1:0];
    w_id_dst    = 5'd0;
    w_id_use_rs = 1'b0;
    w_id_use_rt = 1'b0;
    case (w_id_kind)
      K_ADD, K_SUB: begin
        w_id_dst    = w_id_rd;
        w_id_use_rs = 1'b1;
        w_id_use_rt = 1'b1;
      end
      K_LDI: w_id_dst = w_id_rt;
      K_LW: begin
        w_id_dst    = w_id_rt;
        w_id_use_rs = 1'b1;
      end
      K_SW: begin
        w_id_use_rs = 1'b1;
        w_id_use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // A load in EX cannot forward in time, so hold ID one cycle when it
  // consumes the load's destination. Built only from registered state.
  assign w_stall = r_id_vld && r_ex.valid && (r_ex.kind == K_LW) &&
                   (r_ex.dst != 5'd0) &&
                   ((w_id_use_rs && (w_id_rs == r_ex.dst)) ||
                    (w_id_use_rt && (w_id_rt == r_ex.dst)));

  assign in_ready = !w_stall;

  assign w_wb_we = r_wb.valid && writes_reg(r_wb.kind) && (r_wb.dst != 5'd0);

  pipeline_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_ra_idx  (w_id_rs[RW-1:0]),
    .o_ra_data (w_rf_a),
    .i_rb_idx  (w_id_rt[RW-1:0]),
    .o_rb_data (w_rf_b),
    .i_we      (w_wb_we),
    .i_wa_idx  (r_wb.dst[RW-1:0]),
    .i_wd      (r_wb_res)
  );

  // A load sitting in MEM has no data yet; the interlock keeps consumers
  // away from it, so only ALU/LDI results forward from MEM.
  assign w_mem_fwd = r_mem.valid && writes_reg(r_mem.kind) &&
                     (r_mem.kind != K_LW) && (r_mem.dst != 5'd0);

  // EX operand selection (MEM is younger than WB, so it wins) and ALU.
  always_comb begin
    w_ex_a = r_ex_a;
    if (w_wb_we && (r_wb.dst == r_ex_rs))    w_ex_a = r_wb_res;
    if (w_mem_fwd && (r_mem.dst == r_ex_rs)) w_ex_a = r_mem_res;

    w_ex_b = r_ex_b;
    if (w_wb_we && (r_wb.dst == r_ex_rt))    w_ex_b = r_wb_res;
    if (w_mem_fwd && (r_mem.dst == r_ex_rt)) w_ex_b = r_mem_res;

    case (r_ex.kind)
      K_ADD:      w_ex_res = w_ex_a + w_ex_b;
      K_SUB:      w_ex_res = w_ex_a - w_ex_b;
      K_LDI:      w_ex_res = r_ex_imm;
      K_LW, K_SW: w_ex_res = w_ex_a + r_ex_imm;
      default:    w_ex_res = '0;
    endcase
  end

  // Address wraps by simply dropping the upper bits of the sum.
  assign w_mem_addr  = r_mem_res[AW-1:0];
  assign w_mem_rdata = r_dmem[w_mem_addr];
  assign w_mem_val   = (r_mem.kind == K_LW) ? w_mem_rdata : r_mem_res;

  // ID register: accept on handshake, hold on stall, otherwise take a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_vld   <= 1'b0;
      r_id_instr <= '0;
    end else if (!w_stall) begin
      r_id_vld <= in_valid;
      if (in_valid) r_id_instr <= instruction;
    end
  end

  // EX register: operands from the register file, bubble during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex     <= '0;
      r_ex_rs  <= '0;
      r_ex_rt  <= '0;
      r_ex_a   <= '0;
      r_ex_b   <= '0;
      r_ex_imm <= '0;
    end else begin
      if (w_stall) r_ex <= '0;
      else         r_ex <= '{valid: r_id_vld, kind: w_id_kind, dst: w_id_dst};
      r_ex_rs  <= w_id_rs;
      r_ex_rt  <= w_id_rt;
      r_ex_a   <= w_rf_a;
      r_ex_b   <= w_rf_b;
      r_ex_imm <= w_id_imm;
    end
  end

  // MEM register: ALU result (or address) and store data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem     <= '0;
      r_mem_res <= '0;
      r_mem_sd  <= '0;
    end else begin
      r_mem     <= r_ex;
      r_mem_res <= w_ex_res;
      r_mem_sd  <= w_ex_b;
    end
  end

  // Data memory: cleared by reset, written by a store in MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        r_dmem[AW'(i)] <= '0;
      end
    end else if (r_mem.valid && (r_mem.kind == K_SW)) begin
      r_dmem[w_mem_addr] <= r_mem_sd;
    end
  end

  // WB register: final value that drives the result port and the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb     <= '0;
      r_wb_res <= '0;
    end else begin
      r_wb     <= r_mem;
      r_wb_res <= w_mem_val;
    end
  end

  // Retirement and load-use stall counters, both free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
      r_stalls  <= '0;
    end else begin
      if (r_wb.valid) r_retired <= r_retired + 32'd1;
      if (w_stall)    r_stalls  <= r_stalls + 32'd1;
    end
  end

  assign result_valid  = w_wb_we;
  assign result_rd     = r_wb.dst[RW-1:0];
  assign result        = r_wb_res;
  assign retired_count = r_retired;
  assign stall_count   = r_stalls;

endmodule

// File: tb/tb_pipeline_core_p.sv
// Directed bench for pipeline_core_p with hand-computed write-back values.
module tb_pipeline_core_p;

  localparam logic [5:0] T_ADD = 6'b000000;
  localparam logic [5:0] T_SUB = 6'b000001;
  localparam logic [5:0] T_LDI = 6'b000010;
  localparam logic [5:0] T_LW  = 6'b000011;
  localparam logic [5:0] T_SW  = 6'b000100;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        result_valid;
  logic [4:0]  result_rd;
  logic [31:0] result;
  logic [31:0] retired_count;
  logic [31:0] stall_count;

  int n_cmp;
  int n_bad;
  int cyc;
  int rdy_low;
  int last_acc;

  logic [4:0]  q_rd  [$];
  logic [31:0] q_val [$];
  int          q_cyc [$];
  logic [4:0]  e_rd  [$];
  logic [31:0] e_val [$];

  logic [4:0]  a_rs [6] = '{5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
  logic [4:0]  a_rt [6] = '{5'd2, 5'd1, 5'd1, 5'd2, 5'd6, 5'd1};
  logic [4:0]  a_rd [6] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
  logic [31:0] a_v  [6] = '{32'd3, 32'd4, 32'd5, 32'd7, 32'd14, 32'd15};

  pipeline_core_p #(
    .DATA_W     (32),
    .NUM_REGS   (32),
    .DMEM_DEPTH (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instruction   (instruction),
    .result_valid  (result_valid),
    .result_rd     (result_rd),
    .result        (result),
    .retired_count (retired_count),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write-back pulse and every not-ready cycle, mid-cycle.
  always @(negedge clk) begin
    if (result_valid) begin
      q_rd.push_back(result_rd);
      q_val.push_back(result);
      q_cyc.push_back(cyc);
    end
    if (!in_ready) rdy_low <= rdy_low + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic int cyc_at(input int i);
    return (q_cyc.size() > i) ? q_cyc[i] : -1000;
  endfunction

  function automatic logic [31:0] rd_at(input int i);
    return (q_rd.size() > i) ? {27'd0, q_rd[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] val_at(input int i);
    return (q_val.size() > i) ? q_val[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] v);
    e_rd.push_back(rd);
    e_val.push_back(v);
  endtask

  // Present one instruction at a negedge; returns at the negedge after it was taken.
  task automatic send(input logic [31:0] ins);
    int g;
    g = 0;
    in_valid    = 1'b1;
    instruction = ins;
    while (!in_ready && g < 8) begin
      @(negedge clk);
      g++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    last_acc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, q_rd.size(), e_rd.size());
    for (int i = 0; i < e_rd.size(); i++) begin
      chk($sformatf("%s_rd%0d", tag, i), rd_at(i), {27'd0, e_rd[i]});
      chk($sformatf("%s_val%0d", tag, i), val_at(i), e_val[i]);
    end
    q_rd.delete();
    q_val.delete();
    q_cyc.delete();
    e_rd.delete();
    e_val.delete();
  endtask

  initial begin
    int lat_base;
    int rl0;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    rdy_low = 0;
    last_acc = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    instruction = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_result_rd", 32'(result_rd), 32'd0);
    chk("rst_retired", retired_count, 32'd0);
    chk("rst_stalls", stall_count, 32'd0);

    // LDI/LDI/ADD/SUB back-to-back: forwarding from MEM and WB, wrap on SUB
    send(enc_i(T_LDI, 5'd0, 5'd5, 16'd7));  lat_base = last_acc; expect_wb(5'd5, 32'd7);
    send(enc_i(T_LDI, 5'd0, 5'd6, 16'd3));  expect_wb(5'd6, 32'd3);
    send(enc_r(T_ADD, 5'd5, 5'd6, 5'd1));   expect_wb(5'd1, 32'd10);
    send(enc_r(T_SUB, 5'd6, 5'd5, 5'd2));   expect_wb(5'd2, 32'hFFFF_FFFC);
    idle(8);
    chk("p1_latency", cyc_at(0) - lat_base, 32'd3);
    chk("p1_throughput", cyc_at(3) - cyc_at(0), 32'd3);
    chk("p1_stalls", stall_count, 32'd0);
    drain("p1");

    // SW then LW then dependent ADD: one interlock cycle
    rl0 = rdy_low;
    send(enc_i(T_SW, 5'd0, 5'd5, 16'd4));
    send(enc_i(T_LW, 5'd0, 5'd7, 16'd4));   expect_wb(5'd7, 32'd7);
    send(enc_r(T_ADD, 5'd7, 5'd7, 5'd8));   expect_wb(5'd8, 32'd14);
    idle(8);
    chk("p2_ready_low_cycles", rdy_low - rl0, 32'd1);
    chk("p2_stalls", stall_count, 32'd1);
    chk("p2_gap", cyc_at(1) - cyc_at(0), 32'd2);
    drain("p2");

    // Address wrap, negative offset, r0 write drop, sign extension
    send(enc_i(T_LW, 5'd0, 5'd9, 16'd20));        expect_wb(5'd9, 32'd7);
    send(enc_i(T_LDI, 5'd0, 5'd0, 16'd5));
    send(enc_r(T_ADD, 5'd0, 5'd0, 5'd3));         expect_wb(5'd3, 32'd0);
    send(enc_i(T_LW, 5'd5, 5'd10, 16'hFFFD));     expect_wb(5'd10, 32'd7);
    send(enc_i(T_LDI, 5'd0, 5'd11, 16'h8000));    expect_wb(5'd11, 32'hFFFF_8000);
    send(enc_r(T_ADD, 5'd11, 5'd11, 5'd12));      expect_wb(5'd12, 32'hFFFF_0000);
    idle(8);
    chk("p3_stalls", stall_count, 32'd1);
    chk("p3_retired", retired_count, 32'd13);
    drain("p3");

    // Three in flight, then a one-cycle reset with a request still offered
    send(enc_i(T_LDI, 5'd0, 5'd1, 16'd1));
    send(enc_i(T_LDI, 5'd0, 5'd2, 16'd2));
    send(enc_i(T_LDI, 5'd0, 5'd3, 16'd3));
    instruction = enc_r(T_ADD, 5'd1, 5'd2, 5'd4);
    in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("p4_in_ready", 32'(in_ready), 32'd1);
    chk("p4_result", result, 32'd0);
    idle(8);
    chk("p4_retired", retired_count, 32'd0);
    chk("p4_stalls", stall_count, 32'd0);
    drain("p4");

    // Registers and memory must read back cleared after reset
    send(enc_r(T_ADD, 5'd1, 5'd2, 5'd4));   expect_wb(5'd4, 32'd0);
    send(enc_i(T_LW, 5'd0, 5'd5, 16'd4));   expect_wb(5'd5, 32'd0);
    send(enc_i(T_LDI, 5'd0, 5'd1, 16'd1));  expect_wb(5'd1, 32'd1);
    send(enc_i(T_LDI, 5'd0, 5'd2, 16'd2));  expect_wb(5'd2, 32'd2);
    // Six ADDs with in_valid alternating 1/0
    for (int i = 0; i < 6; i++) begin
      send(enc_r(T_ADD, a_rs[i], a_rt[i], a_rd[i]));
      expect_wb(a_rd[i], a_v[i]);
      in_valid = 1'b0;
      @(negedge clk);
    end
    idle(8);
    for (int i = 4; i < 9; i++) begin
      chk($sformatf("p5_spacing%0d", i), cyc_at(i + 1) - cyc_at(i), 32'd2);
    end
    // 2 post-reset probes + 2 LDI + 6 ADD
    chk("p5_retired", retired_count, 32'd10);
    chk("p5_stalls", stall_count, 32'd0);
    drain("p5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_core_p.md
PIPELINE_CORE_P -- requirements
Module: pipeline_core_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width; legal range 8..32.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count; a power of 2, at most 32; RW = log2(NUM_REGS).
REQ-003 SHALL have parameter DMEM_DEPTH, default 16: data-memory words; a power of 2.
REQ-004 SHALL use one clock and synchronous active-high reset; ports as follows.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 in_valid  in  1  instruction present.
REQ-008 in_ready  out  1  core accepts instruction this cycle.
REQ-009 instruction  in  32  fields: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm; register indices use their low RW bits.
REQ-010 result_valid  out  1  one-cycle write-back strobe.
REQ-011 result_rd  out  RW  destination register written.
REQ-012 result  out  DATA_W  value written.
REQ-013 retired_count  out  32  count of accepted instructions that have left WB.
REQ-014 stall_count  out  32  count of load-use stall cycles.

Function
REQ-015 Opcode set: 000000 ADD rd=rs+rt; 000001 SUB rd=rs-rt; 000010 LDI rt=sext(imm); 000011 LW rt=mem[rs+sext(imm)]; 000100 SW mem[rs+sext(imm)]=rt; any other op is NOP.
REQ-016 Pipeline SHALL have 4 stages: ID (decode/regread), EX, MEM, WB; transfer occurs when in_valid&&in_ready at a rising edge.
REQ-017 Latency: result_valid SHALL assert in the cycle after the 4th rising edge counted from and including the accepting edge; throughput is 1 instruction/cycle without hazards.
REQ-018 Arithmetic SHALL wrap modulo 2^DATA_W; imm SHALL be sign-extended to DATA_W.
REQ-019 Memory address SHALL be (rs+sext(imm)) modulo DMEM_DEPTH (wrap-around, no error).
REQ-020 Register 0 SHALL read as 0; writes to it SHALL be dropped, with no result_valid pulse.
REQ-021 EX operands SHALL forward from MEM and then WB, youngest first; register file SHALL bypass a same-cycle WB write to an ID read.
REQ-022 Load-use: when EX holds LW with rt!=0 and ID reads that rt, in_ready SHALL drop for exactly 1 cycle, a bubble SHALL enter EX, and stall_count SHALL increment by 1.
REQ-023 When in_valid is low, a bubble SHALL enter and produce no result_valid and no retirement.
REQ-024 result_valid SHALL pulse only for ADD, SUB, LDI, LW with destination !=0; SW and NOP retire silently.
REQ-025 Counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 in_ready SHALL be a function of registered state only (no combinational path from in_valid).

Reset
REQ-027 Reset SHALL clear all stage valids, registers, data memory and counters; outputs SHALL be result_valid=0, result=0, result_rd=0, in_ready=1 in the cycle after reset.
REQ-028 Reset mid-operation SHALL discard all in-flight instructions with no subsequent result_valid; reset has priority over the handshake.

Structure
REQ-029 Package pipeline_pkg SHALL hold the opcode constants, the stage-register struct typedefs and the default parameter values.
REQ-030 The register file SHALL be a sub-module pipeline_regfile (2 read ports, 1 write port, r0 hardwired to 0, write-through bypass).

Verification
REQ-031 LDI r5=7; LDI r6=3; ADD r1=r5+r6 back-to-back -> result_rd=1, result=10, stall_count=0.
REQ-032 Then SUB r2=r6-r5 -> result=0xFFFFFFFC (DATA_W=32).
REQ-033 SW r5 to [r0+4]; LW r7=[r0+4]; ADD r8=r7+r7 -> one in_ready low cycle, stall_count=1, r7 result=7, r8 result=14.
REQ-034 LW r9=[r0+20] with DMEM_DEPTH=16 -> reads word 4, result=7; LDI r0=5 -> no pulse; ADD r3=r0+r0 -> result=0.
REQ-035 Three instructions in flight, then reset for one cycle -> no result_valid afterward; retired_count=0 and stall_count=0.
REQ-036 Alternating in_valid 1/0 over 6 ADDs -> exactly 6 pulses spaced 2 cycles apart; retired_count=6.
